// File: rtl/mult_unit_pipelined_if.sv
// Issue/result bundle for the pipelined multiply unit.
// The issue side is the master; the multiply unit is the slave.
interface mult_unit_pipelined_if #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned ROB_IX_WIDTH = 3
);
    logic                    valid_in;
    logic [1:0]              op_in;
    logic [WIDTH-1:0]        rval1_in;
    logic [WIDTH-1:0]        rval2_in;
    logic [ROB_IX_WIDTH-1:0] rob_ix_in;
    logic                    read_in;
    logic                    flush_in;
    logic                    ready_out;
    logic                    valid_out;
    logic [WIDTH-1:0]        data_out;
    logic [ROB_IX_WIDTH-1:0] rob_ix_out;

    modport master (
        output valid_in, op_in, rval1_in, rval2_in, rob_ix_in, read_in, flush_in,
        input  ready_out, valid_out, data_out, rob_ix_out
    );

    modport slave (
        input  valid_in, op_in, rval1_in, rval2_in, rob_ix_in, read_in, flush_in,
        output ready_out, valid_out, data_out, rob_ix_out
    );
endinterface

// File: rtl/mult_unit_pipelined.sv
// Fully pipelined RV32M multiply unit: in-order output FIFO, credit-based ready,
// flush of all in-flight work.
module mult_unit_pipelined #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned ROB_IX_WIDTH    = 3,
    parameter int unsigned MAX_OUTSTANDING = 5
) (
    input logic                  clk_in,
    input logic                  rst_in,
    mult_unit_pipelined_if.slave bus
);
    localparam int unsigned ProdWidth = 2 * WIDTH;
    localparam int unsigned PtrWidth  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntWidth  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntWidth-1:0] MaxOut  = CntWidth'(MAX_OUTSTANDING);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MAX_OUTSTANDING - 1);

    logic                    ready;
    logic                    accept;
    logic                    pop;
    logic [ProdWidth-1:0]    a_ext;
    logic [ProdWidth-1:0]    b_ext;
    logic [ProdWidth-1:0]    in_prod;

    logic                    tl_valid;
    logic [1:0]              tl_op;
    logic [ROB_IX_WIDTH-1:0] tl_tag;
    logic [ProdWidth-1:0]    tl_prod;
    logic [WIDTH-1:0]        tl_res;

    logic [WIDTH-1:0]        buf_data_q [MAX_OUTSTANDING];
    logic [ROB_IX_WIDTH-1:0] buf_tag_q  [MAX_OUTSTANDING];
    logic [PtrWidth-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]     buf_cnt_q, outstanding_q;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign ready  = (outstanding_q < MaxOut);
    assign accept = bus.valid_in && ready && !bus.flush_in;
    assign pop    = (buf_cnt_q != '0) && bus.read_in && !bus.flush_in;

    // Sign-extend per op so one 2W-bit product (mod 2^2W) serves all four modes.
    always_comb begin
        a_ext = {{WIDTH{(bus.op_in == 2'b01 || bus.op_in == 2'b10) && bus.rval1_in[WIDTH-1]}},
                 bus.rval1_in};
        b_ext = {{WIDTH{(bus.op_in == 2'b01) && bus.rval2_in[WIDTH-1]}}, bus.rval2_in};
        in_prod = a_ext * b_ext;
    end

    // The output buffer write is the final stage, so LATENCY-1 registers sit before it.
    if (LATENCY == 1) begin : g_no_stage
        assign tl_valid = accept;
        assign tl_op    = bus.op_in;
        assign tl_tag   = bus.rob_ix_in;
        assign tl_prod  = in_prod;
    end else begin : g_stages
        localparam int Stages = LATENCY - 1;

        logic [Stages-1:0]       st_valid_q;
        logic [1:0]              st_op_q   [Stages];
        logic [ROB_IX_WIDTH-1:0] st_tag_q  [Stages];
        logic [ProdWidth-1:0]    st_prod_q [Stages];

        always_ff @(posedge clk_in) begin
            if (rst_in || bus.flush_in) begin
                st_valid_q <= '0;
            end else begin
                st_valid_q[0] <= accept;
                for (int i = 1; i < Stages; i++) st_valid_q[i] <= st_valid_q[i-1];
            end
        end

        always_ff @(posedge clk_in) begin
            st_op_q[0]   <= bus.op_in;
            st_tag_q[0]  <= bus.rob_ix_in;
            st_prod_q[0] <= in_prod;
            for (int i = 1; i < Stages; i++) begin
                st_op_q[i]   <= st_op_q[i-1];
                st_tag_q[i]  <= st_tag_q[i-1];
                st_prod_q[i] <= st_prod_q[i-1];
            end
        end

        assign tl_valid = st_valid_q[Stages-1];
        assign tl_op    = st_op_q[Stages-1];
        assign tl_tag   = st_tag_q[Stages-1];
        assign tl_prod  = st_prod_q[Stages-1];
    end

    assign tl_res = (tl_op == 2'b00) ? tl_prod[WIDTH-1:0] : tl_prod[ProdWidth-1:WIDTH];

    always_ff @(posedge clk_in) begin
        if (rst_in || bus.flush_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            buf_cnt_q     <= '0;
            outstanding_q <= '0;
        end else begin
            if (tl_valid) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
            buf_cnt_q     <= buf_cnt_q + CntWidth'(tl_valid) - CntWidth'(pop);
            outstanding_q <= outstanding_q + CntWidth'(accept) - CntWidth'(pop);
        end
    end

    // Credits bound the buffer occupancy, so a write never lands on a live entry.
    always_ff @(posedge clk_in) begin
        if (tl_valid) begin
            buf_data_q[wr_ptr_q] <= tl_res;
            buf_tag_q[wr_ptr_q]  <= tl_tag;
        end
    end

    assign bus.ready_out  = ready;
    assign bus.valid_out  = (buf_cnt_q != '0);
    assign bus.data_out   = bus.valid_out ? buf_data_q[rd_ptr_q] : '0;
    assign bus.rob_ix_out = bus.valid_out ? buf_tag_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_mult_unit_pipelined.sv
// Directed self-checking bench for mult_unit_pipelined (default parameters).
module tb_mult_unit_pipelined;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    mult_unit_pipelined_if #(.WIDTH(32), .ROB_IX_WIDTH(3)) bus ();

    mult_unit_pipelined #(
        .WIDTH          (32),
        .LATENCY        (4),
        .ROB_IX_WIDTH   (3),
        .MAX_OUTSTANDING(5)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  m_op  [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [31:0] m_a   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                               32'h80000000, 32'h00000002, 32'h12345678};
    logic [31:0] m_b   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h00000002,
                               32'h80000000, 32'hFFFFFFFF, 32'h00000010};
    logic [31:0] m_exp [7] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000,
                               32'h40000000, 32'h00000001, 32'h23456780};

    // Advance one clock; inputs set and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] tag);
        bus.valid_in  = 1'b1;
        bus.op_in     = op;
        bus.rval1_in  = a;
        bus.rval2_in  = b;
        bus.rob_ix_in = tag;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
        bus.op_in    = 2'b00;
        bus.rval1_in = '0;
        bus.rval2_in = '0;
        bus.rob_ix_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue(2'b00, 32'd9, 32'd9, 3'd7);
        bus.read_in  = 1'b1;
        bus.flush_in = 1'b0;
        repeat (3) step();
        n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        n_chk++; if (bus.data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
        n_chk++; if (bus.rob_ix_out !== 3'd0) begin n_fail++; $display("FAIL reset_rob: got %0d want 0", bus.rob_ix_out); end
        n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 6; c++) begin
            step();
            n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_ignore_valid_in: cyc %0d got %b want 0", c, bus.valid_out); end
        end
    endtask

    task automatic test_basic();
        bus.read_in = 1'b1;
        issue(2'b00, 32'd7, 32'd6, 3'd3);
        step();
        idle();
        for (int c = 1; c < 4; c++) begin
            n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early: cyc %0d got %b want 0", c, bus.valid_out); end
            step();
        end
        n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.valid_out); end
        n_chk++; if (bus.data_out !== 32'd42) begin n_fail++; $display("FAIL basic_data: got %0d want 42", bus.data_out); end
        n_chk++; if (bus.rob_ix_out !== 3'd3) begin n_fail++; $display("FAIL basic_rob: got %0d want 3", bus.rob_ix_out); end
        step();
        n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_modes();
        bus.read_in = 1'b1;
        for (int v = 0; v < 7; v++) begin
            issue(m_op[v], m_a[v], m_b[v], 3'(v));
            step();
            idle();
            repeat (3) step();
            n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL mode_valid[%0d]: got %b want 1", v, bus.valid_out); end
            n_chk++; if (bus.data_out !== m_exp[v]) begin n_fail++; $display("FAIL mode_data[%0d]: got %h want %h", v, bus.data_out, m_exp[v]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        bus.read_in = 1'b1;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            if (cyc < 8) begin
                issue(2'b00, 32'(cyc), 32'(cyc + 1), 3'(cyc));
                n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cyc %0d got %b want 1", cyc, bus.ready_out); end
            end else begin
                idle();
            end
            if (cyc >= 4 && cyc < 12) begin
                n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: cyc %0d got %b want 1", cyc, bus.valid_out); end
                n_chk++; if (bus.data_out !== 32'((cyc - 4) * (cyc - 3))) begin n_fail++; $display("FAIL b2b_data: cyc %0d got %0d want %0d", cyc, bus.data_out, (cyc - 4) * (cyc - 3)); end
                n_chk++; if (bus.rob_ix_out !== 3'(cyc - 4)) begin n_fail++; $display("FAIL b2b_rob: cyc %0d got %0d want %0d", cyc, bus.rob_ix_out, cyc - 4); end
            end else begin
                n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: cyc %0d got %b want 0", cyc, bus.valid_out); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bus.read_in = 1'b0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc < 7) issue(2'b00, 32'(cyc + 1), 32'd2, 3'(cyc));
            else idle();
            n_chk++; if (bus.ready_out !== (cyc < 5)) begin n_fail++; $display("FAIL bp_ready: cyc %0d got %b want %b", cyc, bus.ready_out, cyc < 5); end
            step();
        end
        n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_head_valid: got %b want 1", bus.valid_out); end
        n_chk++; if (bus.rob_ix_out !== 3'd0) begin n_fail++; $display("FAIL bp_head_rob: got %0d want 0", bus.rob_ix_out); end
        bus.read_in = 1'b1;
        step();
        bus.read_in = 1'b0;
        n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.ready_out); end
        step();
        bus.read_in = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, bus.valid_out); end
            n_chk++; if (bus.rob_ix_out !== 3'(i)) begin n_fail++; $display("FAIL bp_drain_rob[%0d]: got %0d want %0d", i, bus.rob_ix_out, i); end
            n_chk++; if (bus.data_out !== 32'(2 * (i + 1))) begin n_fail++; $display("FAIL bp_drain_data[%0d]: got %0d want %0d", i, bus.data_out, 2 * (i + 1)); end
            step();
        end
        n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_extra_op: got valid %b rob %0d want 0", bus.valid_out, bus.rob_ix_out); end
    endtask

    task automatic test_flush();
        bus.read_in = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            issue(2'b00, 32'd11, 32'(cyc + 1), 3'(cyc));
            step();
        end
        n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_pre_buffered: got %b want 1", bus.valid_out); end
        issue(2'b00, 32'd13, 32'd13, 3'd5);
        bus.read_in  = 1'b1;
        bus.flush_in = 1'b1;
        step();
        bus.flush_in = 1'b0;
        n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.valid_out); end
        n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", bus.ready_out); end
        issue(2'b00, 32'd3, 32'd5, 3'd6);
        step();
        idle();
        for (int c = 6; c < 9; c++) begin
            n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_stale: cyc %0d got valid %b rob %0d want 0", c, bus.valid_out, bus.rob_ix_out); end
            step();
        end
        n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_post_valid: got %b want 1", bus.valid_out); end
        n_chk++; if (bus.data_out !== 32'd15) begin n_fail++; $display("FAIL flush_post_data: got %0d want 15", bus.data_out); end
        n_chk++; if (bus.rob_ix_out !== 3'd6) begin n_fail++; $display("FAIL flush_post_rob: got %0d want 6", bus.rob_ix_out); end
        step();
        n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_post_pop: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_reset_midflight();
        bus.read_in = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            issue(2'b00, 32'd5, 32'(cyc + 2), 3'(cyc + 1));
            step();
        end
        rst = 1'b1;
        issue(2'b00, 32'd1, 32'd1, 3'd7);
        step();
        rst = 1'b0;
        idle();
        n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", bus.valid_out); end
        n_chk++; if (bus.data_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", bus.data_out); end
        n_chk++; if (bus.rob_ix_out !== 3'd0) begin n_fail++; $display("FAIL rst_mid_rob: got %0d want 0", bus.rob_ix_out); end
        n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bus.ready_out); end
        bus.read_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: cyc %0d got valid %b rob %0d want 0", c, bus.valid_out, bus.rob_ix_out); end
        end
        bus.read_in = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.read_in  = 1'b0;
        bus.flush_in = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_unit_pipelined.md
Name: mult_unit_pipelined

Overview:
Fully pipelined integer multiply functional unit for the superscalar backend. It accepts one RV32M multiply op per cycle (MUL/MULH/MULHSU/MULHU) tagged with a ROB index, returns results in issue order through an output buffer, and holds each result until the CDB arbiter reads it. It generalises the single-issue fixed-latency multiplier: parametrised width, latency, tag width and outstanding count, with multiple ops in flight, credit-based backpressure and a mispredict flush.

Parameters:
WIDTH, 32, operand/result width in bits
LATENCY, 4, accept-to-valid_out latency in cycles (>=1); number of multiply pipeline stages
ROB_IX_WIDTH, 3, ROB tag width
MAX_OUTSTANDING, 5, max ops accepted but not yet read (pipeline + output buffer); LATENCY+1 gives full throughput

Ports:
clk_in  input  1  clock, all logic on rising edge
rst_in  input  1  synchronous, active-high reset
valid_in  input  1  issue request; accepted at an edge when valid_in && ready_out && !flush_in
op_in  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
rval1_in  input  WIDTH  operand rs1
rval2_in  input  WIDTH  operand rs2
rob_ix_in  input  ROB_IX_WIDTH  destination ROB tag
read_in  input  1  consumer pops head result when valid_out && read_in
flush_in  input  1  squash all in-flight and buffered ops
ready_out  output  1  unit can accept an op this cycle
valid_out  output  1  head result available
data_out  output  WIDTH  head result
rob_ix_out  output  ROB_IX_WIDTH  head result tag

Behaviour:
- Reset (rst_in high at an edge): pipeline valid bits cleared, buffer emptied, outstanding count = 0. After the edge: valid_out=0, data_out=0, rob_ix_out=0, ready_out=1. Reset mid-operation discards every op; no result ever emerges for pre-reset ops. While rst_in is high, valid_in, read_in and flush_in are ignored.
- Arithmetic: full 2*WIDTH product. MUL = low WIDTH bits (signedness irrelevant). MULH = high WIDTH bits of signed×signed. MULHSU = high WIDTH bits of signed rval1 × unsigned rval2. MULHU = high WIDTH bits of unsigned×unsigned.
- Pipeline: LATENCY stages, each with valid bit, op, tag and partial data; advances every cycle and never stalls. An op accepted at edge k writes the output buffer at edge k+LATENCY. valid_out is high in the cycle after that edge (exactly LATENCY cycles after the accept cycle when the buffer was empty).
- Output buffer: in-order FIFO, depth MAX_OUTSTANDING, so it cannot overflow. valid_out = buffer non-empty. data_out/rob_ix_out show the head and are 0 when valid_out=0. Pop on the edge where valid_out && read_in. read_in with valid_out=0 is a no-op. Write and pop on the same edge are both performed.
- Credits: outstanding increments on accept and decrements on pop; both on the same edge leave it unchanged. ready_out = (outstanding < MAX_OUTSTANDING), registered-state only, with no combinational path from read_in or valid_in. When ready_out=0, valid_in is ignored and is not held; the issue logic re-presents the op.
- Results retire strictly in acceptance order. With read_in held high, the unit sustains 1 op/cycle when MAX_OUTSTANDING >= LATENCY+1.
- Flush (flush_in high at an edge, rst_in low): all pipeline valid bits cleared, buffer emptied, outstanding = 0. A valid_in and read_in on the same edge are ignored (no accept, no pop). After the edge: valid_out=0, ready_out=1. An op issued on the next cycle completes normally.
- Pointers and the outstanding counter wrap or size correctly for any MAX_OUTSTANDING that is not a power of two.

Test Plan:
- MUL 7×6, rob 3, accept cycle 0, read_in=1 -> valid_out first high in cycle 4 with data 42, rob_ix 3; popped at that edge, then valid_out=0.
- Modes: MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF. MUL 0x80000000×2 -> 0x00000000. MULH 0x80000000×0x80000000 -> 0x40000000.
- Throughput: 8 back-to-back ops (rob 0..7, a=i, b=i+1) with read_in=1 -> ready_out stays 1; results i*(i+1) on 8 consecutive cycles from cycle 4, in order.
- Backpressure: read_in=0, issue every cycle -> exactly 5 accepted, ready_out=0 from cycle 5, 6th op ignored. Raise read_in for 1 cycle -> head (rob 0) popped, ready_out=1 next cycle, remaining order preserved.
- Flush: 3 ops in flight plus 1 buffered, pulse flush_in with valid_in=1 -> no valid_out for any of them, ready_out=1 next cycle, subsequent MUL 3×5 returns 15 after 4 cycles.
- Reset mid-flight: rst_in for 1 cycle with 4 ops outstanding -> all outputs zero and ready_out=1 after the edge; no stale result ever appears.
